conta_down_mv_tc: RTL and testbench
===================================

Name: conta_down_mv_tc

Overview:
- Programmable down-counter/timer; the count-down counterpart of the team's modulo-(M+1) up counter.
- Loads a modulus M on start, counts M..0 on enabled cycles and flags terminal count.
- Two modes:
  - periodic: auto-reload, same period as the up counter.
  - one-shot: stops at 0 and raises done.
- Used as the tick/timeout source next to the up counters in the Tema2 exercises.

Parameters:
- W, 3, counter and modulus width in bits.

Ports:
- clk  input  1  system clock; everything updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count-enable; when low the count holds.
- start  input  1  load M into the counter and begin running.
- stop  input  1  abort the run and return to IDLE.
- mode  input  1  0 = periodic (auto-reload), 1 = one-shot.
- M  input  W  modulus; sampled only on start.
- q  output  W  current count value (registered).
- tc  output  1  terminal-count pulse, exactly one cycle wide (registered).
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; cleared by start, stop or reset.

Behaviour:
- All state is registered: q, tc, busy, done, internal m_reg (W bits), mode_reg, and a 2-bit state.
- Reset, on a clk edge with reset=1:
  - state=IDLE, q=0, m_reg=0, mode_reg=0, tc=0, busy=0, done=0.
- Priority per edge: reset > stop > start > enable counting.
- tc defaults to 0 every cycle and is set to 1 only on the edges named below.
- IDLE:
  - q holds its last value.
  - start=1 -> m_reg<=M, mode_reg<=mode, q<=M, state RUN, busy<=1. The enable value on that cycle is irrelevant.
- RUN, enable=1:
  - q!=0 -> q<=q-1.
  - q==0, mode_reg=0 -> q<=m_reg, tc<=1, stay in RUN.
  - q==0, mode_reg=1 -> q stays 0, tc<=1, state DONE, busy<=0, done<=1.
- RUN, enable=0: everything holds, no tc.
- RUN, start=1 -> restart: reload from the current M and mode. No tc, even if q==0 on that cycle.
- Any state, stop=1 -> state IDLE, busy<=0, done<=0, q holds its value, no tc.
- DONE:
  - q=0, done=1, busy=0; enable is ignored.
  - start -> behaves as in IDLE, and clears done.
- Timing:
  - Latency from start to the first q=M is 1 cycle.
  - Periodic mode: tc period is exactly M+1 enabled cycles.
  - One-shot mode: tc comes M+1 enabled cycles after the start edge.
- M=0:
  - periodic -> tc=1 on every enabled cycle, q stays 0.
  - one-shot -> DONE on the first enabled cycle.
- Changes on M or mode while running are ignored until the next start.
- All arithmetic is modulo 2^W. q never underflows, because reload or stop always happens at 0.
- The state encoding never reaches the unused value 2'b11. If it does, the next edge goes to IDLE with the reset outputs.

Decomposition:
- Shared package conta_pkg holds:
  - state constants S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10;
  - mode constants MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1.
- No sub-module: a single always block for state/counter plus output registers is natural.
- The package is reused by the up-counter variants.

Test Plan:
- Reset check: reset=1 for 2 cycles with start=1 and enable=1 -> q=0, tc=0, busy=0, done=0 throughout.
- Periodic run: M=2, mode=0, start pulse, then enable=1 constant:
  - q = 2,1,0,2,1,0,2;
  - tc=1 exactly on the cycles q returns to 2;
  - busy=1 throughout.
- One-shot run: M=3, mode=1, start, enable=1:
  - q = 3,2,1,0, then tc=1 together with done=1 and busy=0;
  - q holds 0 for 5 more cycles with no further tc.
- Enable gating: M=4 periodic, enable toggles 1,0,1,0 -> q decrements only on enable=1 cycles; tc spacing = 5 enabled cycles.
- Priority and restart:
  - mid-run at q=1, start with M=6 -> next q=6, no tc;
  - then stop and start asserted together -> IDLE, q holds, busy=0.
- Edge modulus:
  - M=0 periodic -> tc=1 on every enabled cycle;
  - M=7 (W=3) one-shot -> exactly 8 enabled cycles to done;
  - changing M during the run has no effect.

Source files
------------

// File: rtl/conta_pkg.sv
// ----------------------------------------------------------------------------
// conta_pkg
// Shared constants for the Tema2 counter family (up counters and the
// conta_down_mv_tc down-counter/timer).
//   - state encodings for the IDLE / RUN / DONE control FSM
//   - mode encodings for periodic (auto-reload) vs one-shot operation
// ----------------------------------------------------------------------------
package conta_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'b00;
    localparam state_t S_RUN  = 2'b01;
    localparam state_t S_DONE = 2'b10;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage : conta_pkg

// File: rtl/conta_down_mv_tc.sv
// ----------------------------------------------------------------------------
// conta_down_mv_tc
// Programmable down-counter / timer. On start the modulus M is loaded and the
// counter runs M..0 on enabled cycles, pulsing tc for one cycle at terminal
// count. Periodic mode reloads M (period M+1 enabled cycles); one-shot mode
// parks at 0 in DONE.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   enable    in   count enable; count holds when low
//   start     in   load M/mode and (re)start the run
//   stop      in   abort to IDLE, q holds
//   mode      in   0 = periodic, 1 = one-shot (sampled on start)
//   M         in   modulus, W bits (sampled on start)
//   q         out  current count (registered)
//   tc        out  one-cycle terminal-count pulse (registered)
//   busy      out  high while in RUN
//   done      out  high in DONE
//   dbg_state out  current FSM state, for checkers
//
// Control semantics: start/stop/enable are level-sampled on every rising
// edge with priority reset > stop > start > enable; there is no handshake
// and no back-pressure.
// ----------------------------------------------------------------------------
module conta_down_mv_tc
    import conta_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [W-1:0] M,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);

    state_t       state;
    logic [W-1:0] m_reg;
    logic         mode_reg;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        // tc is a pulse: cleared every edge unless a terminal count fires
        tc <= 1'b0;

        if (reset || (state != S_IDLE && state != S_RUN && state != S_DONE)) begin
            // The unused encoding recovers exactly like a reset
            state    <= S_IDLE;
            q        <= '0;
            m_reg    <= '0;
            mode_reg <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            // Same action from IDLE, RUN (restart) and DONE; no tc even if q==0
            m_reg    <= M;
            mode_reg <= mode;
            q        <= M;
            state    <= S_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (enable) begin
                        if (q != '0) begin
                            q <= q - 1'b1;
                        end else if (mode_reg == MODE_PERIODIC) begin
                            q  <= m_reg;
                            tc <= 1'b1;
                        end else begin
                            tc    <= 1'b1;
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold everything; enable is ignored
                end
            endcase
        end
    end

endmodule : conta_down_mv_tc

// File: tb/tb_conta_down_mv_tc.sv
// ----------------------------------------------------------------------------
// tb_conta_down_mv_tc
// Directed, table-driven bench for conta_down_mv_tc (W=3). Each record holds
// the inputs applied before a rising edge and the outputs expected after it.
// A hand-written sequence covers the full-range one-shot run (M=7) with
// gated enable and M disturbed mid-run.
// ----------------------------------------------------------------------------
module tb_conta_down_mv_tc;
    import conta_pkg::*;

    localparam int W = 3;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset, enable, start, stop, mode;
    logic [W-1:0] M;
    logic [W-1:0] q;
    logic         tc, busy, done;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    conta_down_mv_tc #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .M         (M),
        .q         (q),
        .tc        (tc),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic         st;
        logic         sp;
        logic         en;
        logic         md;
        logic [W-1:0] m;
        logic [W-1:0] eq;
        logic         etc;
        logic         ebusy;
        logic         edone;
        logic [1:0]   estate;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic void add(input logic rst, input logic st, input logic sp,
                                input logic en, input logic md, input logic [W-1:0] m,
                                input logic [W-1:0] eq, input logic etc,
                                input logic ebusy, input logic edone,
                                input logic [1:0] estate);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.en = en; v.md = md; v.m = m;
        v.eq = eq; v.etc = etc; v.ebusy = ebusy; v.edone = edone; v.estate = estate;
        vecs.push_back(v);
    endfunction

    // ---------------- driver / checker ----------------
    task automatic drive(input logic rst, input logic st, input logic sp,
                         input logic en, input logic md, input logic [W-1:0] m);
        reset = rst; start = st; stop = sp; enable = en; mode = md; M = m;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] eq, input logic etc,
                         input logic ebusy, input logic edone, input logic [1:0] estate);
        n_vec++;
        if (q !== eq || tc !== etc || busy !== ebusy || done !== edone || dbg_state !== estate) begin
            n_fail++;
            $display("FAIL %s: got q=%0d tc=%b busy=%b done=%b st=%0d, want q=%0d tc=%b busy=%b done=%b st=%0d",
                     name, q, tc, busy, done, dbg_state, eq, etc, ebusy, edone, estate);
        end
    endtask

    initial begin
        int en_cnt;
        bit seen_done;

        reset = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0; mode = 1'b0; M = '0;

        // reset held 2 cycles with start and enable active
        add(1,1,0,1,0,5, 0,0,0,0,S_IDLE);
        add(1,1,0,1,0,5, 0,0,0,0,S_IDLE);
        add(0,0,0,1,0,5, 0,0,0,0,S_IDLE);

        // periodic M=2: 2,1,0,2,1,0,2 ; M/mode changes mid-run ignored
        add(0,1,0,1,0,2, 2,0,1,0,S_RUN);
        add(0,0,0,1,1,5, 1,0,1,0,S_RUN);
        add(0,0,0,1,1,5, 0,0,1,0,S_RUN);
        add(0,0,0,1,0,7, 2,1,1,0,S_RUN);
        add(0,0,0,1,0,7, 1,0,1,0,S_RUN);
        add(0,0,0,1,0,7, 0,0,1,0,S_RUN);
        add(0,0,0,1,0,7, 2,1,1,0,S_RUN);
        // stop: q holds, IDLE ignores enable
        add(0,0,1,1,0,2, 2,0,0,0,S_IDLE);
        add(0,0,0,1,0,2, 2,0,0,0,S_IDLE);

        // one-shot M=3: 3,2,1,0 then tc+done, then parked
        add(0,1,0,1,1,3, 3,0,1,0,S_RUN);
        add(0,0,0,1,0,7, 2,0,1,0,S_RUN);
        add(0,0,0,1,0,7, 1,0,1,0,S_RUN);
        add(0,0,0,1,0,7, 0,0,1,0,S_RUN);
        add(0,0,0,1,0,7, 0,1,0,1,S_DONE);
        for (int i = 0; i < 5; i++) add(0,0,0,1,0,7, 0,0,0,1,S_DONE);

        // start from DONE clears done; enable-gated periodic M=4
        add(0,1,0,0,0,4, 4,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 3,0,1,0,S_RUN);
        add(0,0,0,0,0,4, 3,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 2,0,1,0,S_RUN);
        add(0,0,0,0,0,4, 2,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 1,0,1,0,S_RUN);
        add(0,0,0,0,0,4, 1,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 0,0,1,0,S_RUN);
        add(0,0,0,0,0,4, 0,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 4,1,1,0,S_RUN);
        add(0,0,0,0,0,4, 4,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 3,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 2,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 1,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 0,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 4,1,1,0,S_RUN);

        // restart at q=1 with M=6, then stop+start together -> stop wins
        add(0,0,0,1,0,4, 3,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 2,0,1,0,S_RUN);
        add(0,0,0,1,0,4, 1,0,1,0,S_RUN);
        add(0,1,0,1,0,6, 6,0,1,0,S_RUN);
        add(0,1,1,1,0,2, 6,0,0,0,S_IDLE);

        // restart while q==0 gives no tc
        add(0,1,0,0,0,1, 1,0,1,0,S_RUN);
        add(0,0,0,1,0,1, 0,0,1,0,S_RUN);
        add(0,1,0,1,0,3, 3,0,1,0,S_RUN);

        // M=0 periodic: tc on every enabled cycle
        add(0,1,0,1,0,0, 0,0,1,0,S_RUN);
        add(0,0,0,1,0,0, 0,1,1,0,S_RUN);
        add(0,0,0,1,0,0, 0,1,1,0,S_RUN);
        add(0,0,0,1,0,0, 0,1,1,0,S_RUN);
        add(0,0,0,0,0,0, 0,0,1,0,S_RUN);
        add(0,0,0,1,0,0, 0,1,1,0,S_RUN);

        // M=0 one-shot: DONE on first enabled cycle
        add(0,1,0,1,1,0, 0,0,1,0,S_RUN);
        add(0,0,0,0,1,0, 0,0,1,0,S_RUN);
        add(0,0,0,1,1,0, 0,1,0,1,S_DONE);
        add(0,0,0,1,1,0, 0,0,0,1,S_DONE);
        // stop clears done
        add(0,0,1,1,0,0, 0,0,0,0,S_IDLE);

        // reset mid-run wins over start
        add(0,1,0,0,0,5, 5,0,1,0,S_RUN);
        add(0,0,0,1,0,5, 4,0,1,0,S_RUN);
        add(1,1,0,1,0,5, 0,0,0,0,S_IDLE);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].md, vecs[i].m);
            check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].etc, vecs[i].ebusy,
                  vecs[i].edone, vecs[i].estate);
        end

        // M=7 one-shot, enable toggling, M disturbed: exactly 8 enabled cycles
        drive(0,1,0,0,1,7);
        check("m7_start", 7, 0, 1, 0, S_RUN);
        en_cnt = 0;
        seen_done = 0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            logic en_now;
            en_now = (c % 2 == 0);
            drive(0,0,0,en_now,0,W'(c));
            if (en_now) en_cnt++;
            if (done) begin
                seen_done = 1;
                check("m7_done", 0, 1, 0, 1, S_DONE);
            end else begin
                check($sformatf("m7_q_c%0d", c), W'(7 - en_cnt), 0, 1, 0, S_RUN);
            end
        end
        n_vec++;
        if (!seen_done || en_cnt != 8) begin
            n_fail++;
            $display("FAIL m7_enabled_cycles: got done=%b after %0d enabled cycles, want done after 8",
                     seen_done, en_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_conta_down_mv_tc
